// File: rtl/codes_pkg.sv
// Shared EX-stage encodings: datapath width, ALU operation codes and arbiter constants.
package codes_pkg;
  parameter int DATA_WIDTH   = 64;
  parameter int ARB_STARVE_W = 4;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_control;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;
endpackage

// File: rtl/alu.sv
// Single-cycle combinational EX-stage ALU with a zero flag.
module alu import codes_pkg::*; #(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic [WIDTH-1:0] reg_1,
  input  logic [WIDTH-1:0] reg_2,
  input  alu_control       control,
  input  logic             alu_src,
  input  logic [WIDTH-1:0] sign_extended_imm,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag
);
  localparam int SH_W = $clog2(WIDTH);

  logic [WIDTH-1:0] op_b;
  logic [SH_W-1:0]  shamt;

  assign op_b  = alu_src ? sign_extended_imm : reg_2;
  assign shamt = op_b[SH_W-1:0];

  always_comb begin
    result = '0;
    case (control)
      ALU_ADD:  result = reg_1 + op_b;
      ALU_SUB:  result = reg_1 - op_b;
      ALU_AND:  result = reg_1 & op_b;
      ALU_OR:   result = reg_1 | op_b;
      ALU_XOR:  result = reg_1 ^ op_b;
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(reg_1) < $signed(op_b))};
      ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (reg_1 < op_b)};
      ALU_SLL:  result = reg_1 << shamt;
      ALU_SRL:  result = reg_1 >> shamt;
      ALU_SRA:  result = $unsigned($signed(reg_1) >>> shamt);
      default:  result = '0;
    endcase
  end

  assign zero_flag = (result == '0);
endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between the main pipeline (fixed priority) and a secondary unit,
// with a starvation counter and one registered response slot per requester.
module alu_arbiter #(
  parameter int DATA_WIDTH   = codes_pkg::DATA_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  codes_pkg::alu_control req0_op,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  codes_pkg::alu_control req1_op,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_result,
  output logic                  rsp0_zero,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_result,
  output logic                  rsp1_zero
);
  import codes_pkg::*;

  localparam logic [ARB_STARVE_W-1:0] LIMIT = ARB_STARVE_W'(STARVE_LIMIT);

  logic                    elig0, elig1, grant0, grant1, any_grant;
  req_id_t                 sel;
  logic [DATA_WIDTH-1:0]   alu_a, alu_b, alu_res;
  alu_control              alu_op;
  logic                    alu_zero;

  logic                    rsp0_valid_q, rsp1_valid_q;
  logic [DATA_WIDTH-1:0]   rsp0_result_q, rsp1_result_q;
  logic                    rsp0_zero_q, rsp1_zero_q;
  logic [ARB_STARVE_W-1:0] starve_q, starve_d;

  // A slot being drained this cycle can accept a new result on the same edge.
  assign elig0 = req0_valid && (!rsp0_valid_q || rsp0_ready);
  assign elig1 = req1_valid && (!rsp1_valid_q || rsp1_ready);

  assign grant1    = !rst && elig1 && (!elig0 || (starve_q == LIMIT));
  assign grant0    = !rst && elig0 && !grant1;
  assign any_grant = grant0 || grant1;
  assign sel       = grant1 ? REQ1 : REQ0;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALU_ADD;
    if (any_grant) begin
      alu_a  = (sel == REQ1) ? req1_a  : req0_a;
      alu_b  = (sel == REQ1) ? req1_b  : req0_b;
      alu_op = (sel == REQ1) ? req1_op : req0_op;
    end
  end

  alu #(.WIDTH(DATA_WIDTH)) u_alu (
    .reg_1             (alu_a),
    .reg_2             (alu_b),
    .control           (alu_op),
    .alu_src           (1'b0),
    .sign_extended_imm ({DATA_WIDTH{1'b0}}),
    .result            (alu_res),
    .zero_flag         (alu_zero)
  );

  // Counter only advances while req1 could have been served; a blocked slot freezes it.
  always_comb begin
    starve_d = starve_q;
    if (!req1_valid || grant1)
      starve_d = '0;
    else if (elig1 && (starve_q != LIMIT))
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid_q  <= 1'b0;
      rsp0_result_q <= '0;
      rsp0_zero_q   <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp1_result_q <= '0;
      rsp1_zero_q   <= 1'b0;
      starve_q      <= '0;
    end else begin
      if (grant0) begin
        rsp0_valid_q  <= 1'b1;
        rsp0_result_q <= alu_res;
        rsp0_zero_q   <= alu_zero;
      end else if (rsp0_ready) begin
        rsp0_valid_q  <= 1'b0;
      end
      if (grant1) begin
        rsp1_valid_q  <= 1'b1;
        rsp1_result_q <= alu_res;
        rsp1_zero_q   <= alu_zero;
      end else if (rsp1_ready) begin
        rsp1_valid_q  <= 1'b0;
      end
      starve_q <= starve_d;
    end
  end

  assign rsp0_valid  = rsp0_valid_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp0_zero   = rsp0_zero_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp1_result = rsp1_result_q;
  assign rsp1_zero   = rsp1_zero_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic against a cycle model.
module tb_alu_arbiter;
  import codes_pkg::*;

  localparam int W     = 64;
  localparam int LIMIT = 4;

  logic          clk, rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  alu_control    req0_op, req1_op;
  logic          rsp0_valid, rsp0_ready, rsp0_zero, rsp1_valid, rsp1_ready, rsp1_zero;
  logic [W-1:0]  rsp0_result, rsp1_result;

  alu_arbiter #(.DATA_WIDTH(W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: response slots as the consumers see them, and req1's loss streak.
  bit           m_v[2];
  logic [W-1:0] m_res[2];
  bit           m_z[2];
  int           m_cnt;
  bit           hold0, hold1, obs_r0, obs_r1;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b, input int op);
    int sh;
    sh = int'(b % W);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return ($signed(a) < $signed(b)) ? 1 : 0;
      6: return (a < b) ? 1 : 0;
      7: return a << sh;
      8: return a >> sh;
      9: return $signed(a) >>> sh;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_v[i] = 0; m_res[i] = '0; m_z[i] = 0;
    end
    m_cnt = 0; hold0 = 0; hold1 = 0;
  endtask

  // One clock cycle: drive at negedge, check grants, advance model, check registers after the edge.
  task automatic step(input bit v0, input logic [W-1:0] a0, input logic [W-1:0] b0, input int op0,
                      input bit v1, input logic [W-1:0] a1, input logic [W-1:0] b1, input int op1,
                      input bit rr0, input bit rr1);
    bit e0, e1, g0, g1;
    logic [W-1:0] r;
    @(negedge clk);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = alu_control'(op0);
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = alu_control'(op1);
    rsp0_ready = rr0; rsp1_ready = rr1;
    #1;
    e0 = v0 && (!m_v[0] || rr0);
    e1 = v1 && (!m_v[1] || rr1);
    g1 = e1 && (!e0 || m_cnt == LIMIT);
    g0 = e0 && !g1;
    obs_r0 = req0_ready; obs_r1 = req1_ready;
    chk("req0_ready", W'(req0_ready), W'(g0));
    chk("req1_ready", W'(req1_ready), W'(g1));
    if (g0) begin
      r = ref_alu(a0, b0, op0); m_v[0] = 1; m_res[0] = r; m_z[0] = (r == 0);
    end else if (rr0) m_v[0] = 0;
    if (g1) begin
      r = ref_alu(a1, b1, op1); m_v[1] = 1; m_res[1] = r; m_z[1] = (r == 0);
    end else if (rr1) m_v[1] = 0;
    if (!v1 || g1) m_cnt = 0;
    else if (e1 && m_cnt < LIMIT) m_cnt++;
    hold0 = v0 && !g0;
    hold1 = v1 && !g1;
    @(posedge clk);
    #1;
    chk("rsp0_valid", W'(rsp0_valid), W'(m_v[0]));
    chk("rsp0_result", rsp0_result, m_res[0]);
    chk("rsp0_zero", W'(rsp0_zero), W'(m_z[0]));
    chk("rsp1_valid", W'(rsp1_valid), W'(m_v[1]));
    chk("rsp1_result", rsp1_result, m_res[1]);
    chk("rsp1_zero", W'(rsp1_zero), W'(m_z[1]));
    chk("starve_cnt", W'(dut.starve_q), W'(m_cnt));
  endtask

  // Asynchronous reset asserted mid-cycle with both requesters valid.
  task automatic rst_mid(input string tag);
    #2;
    req0_valid = 1; req1_valid = 1;
    rst = 1;
    #1;
    chk({tag, "_req0_ready"}, W'(req0_ready), 0);
    chk({tag, "_req1_ready"}, W'(req1_ready), 0);
    chk({tag, "_rsp0_valid"}, W'(rsp0_valid), 0);
    chk({tag, "_rsp1_valid"}, W'(rsp1_valid), 0);
    chk({tag, "_rsp0_result"}, rsp0_result, 0);
    chk({tag, "_rsp1_result"}, rsp1_result, 0);
    chk({tag, "_rsp_zero"}, W'({rsp0_zero, rsp1_zero}), 0);
    chk({tag, "_starve"}, W'(dut.starve_q), 0);
    model_reset();
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    @(negedge clk);
    rst = 0;
  endtask

  localparam logic [W-1:0] NEG20 = 64'hFFFF_FFFF_FFFF_FFEC;
  localparam logic [W-1:0] NEG10 = 64'hFFFF_FFFF_FFFF_FFF6;

  initial begin
    logic [W-1:0] ra0, rb0, ra1, rb1;
    int rop0, rop1;
    bit rv0, rv1;
    model_reset();
    rst = 1;
    req0_valid = 1; req0_a = '0; req0_b = '0; req0_op = ALU_ADD;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_op = ALU_ADD;
    rsp0_ready = 0; rsp1_ready = 0;
    #12;
    chk("reset_req0_ready", W'(req0_ready), 0);
    chk("reset_rsp_valid", W'({rsp0_valid, rsp1_valid}), 0);
    chk("reset_results", rsp0_result | rsp1_result, 0);
    @(negedge clk);
    rst = 0; req0_valid = 0;

    // Uncontended ADD, then slot drains when nothing follows.
    step(1, 10, 20, 0, 0, 0, 0, 0, 1, 1);
    chk("add_ready", W'(obs_r0), 1);
    chk("add_result", rsp0_result, 30);
    chk("add_zero", W'(rsp0_zero), 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("add_drain", W'(rsp0_valid), 0);

    // Contention: req0 first, req1 the next cycle.
    step(1, 10, 20, 1, 1, 10, 20, 2, 1, 1);
    chk("cont_g0", W'({obs_r0, obs_r1}), 2'b10);
    chk("cont_sub", rsp0_result, NEG10);
    step(0, 0, 0, 0, 1, 10, 20, 2, 1, 1);
    chk("cont_g1", W'(obs_r1), 1);
    chk("cont_and", rsp1_result, 0);
    chk("cont_and_zero", W'(rsp1_zero), 1);

    // Starvation: req1 wins exactly on the fifth contested cycle.
    for (int i = 0; i < 6; i++) begin
      step(1, 3, 4, 0, 1, 5, 6, 0, 1, 1);
      chk("starve_g1", W'(obs_r1), W'(i == LIMIT));
      chk("starve_g0", W'(obs_r0), W'(i != LIMIT));
    end

    // Back-pressure on slot 0 leaves req1 free to go.
    step(1, 5, 6, 0, 0, 0, 0, 0, 1, 1);
    step(1, 7, 8, 3, 1, 10, NEG20, 6, 0, 1);
    chk("bp_g0", W'(obs_r0), 0);
    chk("bp_g1", W'(obs_r1), 1);
    chk("bp_hold", rsp0_result, 11);
    chk("bp_sltu", rsp1_result, 1);
    step(1, 7, 8, 3, 0, 0, 0, 0, 1, 1);
    chk("bp_release", W'(obs_r0), 1);
    chk("bp_or", rsp0_result, 15);

    // Back-to-back issue keeps valid high.
    step(1, 1, 1, 0, 0, 0, 0, 0, 1, 1);
    chk("b2b_first", rsp0_result, 2);
    step(1, 10, 20, 3, 0, 0, 0, 0, 1, 1);
    chk("b2b_second", rsp0_result, 30);
    chk("b2b_valid", W'(rsp0_valid), 1);

    // Reset with rsp1 holding a result.
    step(0, 0, 0, 0, 1, 3, 4, 0, 1, 0);
    chk("rst1_pre", W'(rsp1_valid), 1);
    rst_mid("rst1");
    step(1, 2, 2, 0, 1, 9, 9, 0, 1, 1);
    chk("rst1_prio", W'({obs_r0, obs_r1}), 2'b10);

    // Reset with counter at 3 and rsp0 occupied.
    step(1, 2, 2, 0, 1, 9, 9, 0, 1, 1);
    step(1, 2, 2, 0, 1, 9, 9, 0, 1, 1);
    chk("rst2_pre", W'(rsp0_valid), 1);
    rst_mid("rst2");

    // Random traffic; requests held stable while waiting.
    for (int n = 0; n < 400; n++) begin
      rv0 = hold0 || ($urandom_range(0, 3) != 0);
      rv1 = hold1 || ($urandom_range(0, 3) != 0);
      if (hold0) begin
        ra0 = req0_a; rb0 = req0_b; rop0 = int'(req0_op);
      end else begin
        ra0 = {$urandom, $urandom}; rop0 = $urandom_range(0, 9);
        rb0 = ($urandom_range(0, 4) == 0) ? ra0 : W'($urandom_range(0, 200));
      end
      if (hold1) begin
        ra1 = req1_a; rb1 = req1_b; rop1 = int'(req1_op);
      end else begin
        ra1 = W'($urandom_range(0, 100)); rop1 = $urandom_range(0, 9);
        rb1 = ($urandom_range(0, 4) == 0) ? ra1 : {$urandom, $urandom};
      end
      step(rv0, ra0, rb0, rop0, rv1, ra1, rb1, rop1,
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
